// File: rtl/jk_pkg.sv
// Shared types and the J/K excitation rule for the jkff pattern driver.
package jk_pkg;

  typedef enum logic [1:0] {IDLE, INIT, SEND, DRAIN} jk_state_t;

  localparam int unsigned EXC_MIN    = 0;
  localparam int unsigned EXC_TOGGLE = 1;
  localparam int unsigned ERR_MAX    = 255;

  // {j, k} that moves a JK flip-flop from q to t; the free input is filled per mode.
  function automatic logic [1:0] jk_excite(input logic q, input logic t,
                                           input int unsigned mode);
    logic fill;
    fill = (mode == EXC_TOGGLE) ? (q ^ t) : 1'b0;
    if (!q) jk_excite = {t, fill};
    else    jk_excite = {fill, ~t};
  endfunction

endpackage

// File: rtl/jk_exc_reg.sv
// Registered J/K excitation plus the model of the flip-flop state it produces.
module jk_exc_reg
  import jk_pkg::*;
#(
  parameter int unsigned EXC_MODE = EXC_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic load,
  input  logic t,
  output logic j_o,
  output logic k_o
);

  logic q_exp;

  // Idle cycles drive hold (0/0) so the flip-flop keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_o   <= 1'b0;
      k_o   <= 1'b0;
      q_exp <= 1'b0;
    end else if (init) begin
      j_o   <= 1'b0;
      k_o   <= 1'b1;
      q_exp <= 1'b0;
    end else if (load) begin
      {j_o, k_o} <= jk_excite(q_exp, t, EXC_MODE);
      q_exp      <= t;
    end else begin
      j_o <= 1'b0;
      k_o <= 1'b0;
    end
  end

endmodule

// File: rtl/jk_pattern_driver.sv
// Serialises target words into J/K excitation for a jkff and checks its q
// against the expected bit two edges later.
module jk_pattern_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned EXC_MODE = EXC_MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid_i,
  input  logic [WIDTH-1:0] tgt_data_i,
  output logic             tgt_ready_o,
  output logic             j_o,
  output logic             k_o,
  input  logic             q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  jk_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_idx;
  logic             synced;
  logic             chk1_en, chk1_exp, chk2_en, chk2_exp;
  logic             accept_c, exc_init_c, exc_load_c, exc_t_c;

  assign accept_c   = tgt_valid_i && tgt_ready_o;
  assign exc_init_c = (state == IDLE) && accept_c && !synced;
  assign exc_load_c = ((state == IDLE) && accept_c && synced) ||
                      (state == INIT) || (state == SEND);
  // Bit 0 comes straight from the input on a synced acceptance.
  assign exc_t_c    = (state == IDLE) ? tgt_data_i[0] : shreg[0];

  jk_exc_reg #(.EXC_MODE(EXC_MODE)) u_exc (
    .clk  (clk),
    .rst  (rst),
    .init (exc_init_c),
    .load (exc_load_c),
    .t    (exc_t_c),
    .j_o  (j_o),
    .k_o  (k_o)
  );

  // Word sequencing: accept, optional INIT, one SEND cycle per bit, DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      synced      <= 1'b0;
      tgt_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            tgt_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (synced) begin
              shreg   <= tgt_data_i >> 1;
              bit_idx <= CW'(1);
              state   <= (WIDTH == 1) ? DRAIN : SEND;
            end else begin
              shreg   <= tgt_data_i;
              bit_idx <= '0;
              synced  <= 1'b1;
              state   <= INIT;
            end
          end
        end
        INIT, SEND: begin
          shreg <= shreg >> 1;
          if (bit_idx == LAST_IDX) begin
            state <= DRAIN;
          end else begin
            bit_idx <= bit_idx + CW'(1);
            state   <= SEND;
          end
        end
        DRAIN: begin
          // Stage 1 empty means the final check happens at this edge.
          if (!chk1_en) begin
            state       <= IDLE;
            done_o      <= 1'b1;
            tgt_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expected bit trails the excitation by two edges to meet the sampled q.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk1_en   <= 1'b0;
      chk1_exp  <= 1'b0;
      chk2_en   <= 1'b0;
      chk2_exp  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      chk1_en  <= exc_load_c;
      chk1_exp <= exc_t_c;
      chk2_en  <= chk1_en;
      chk2_exp <= chk1_exp;
      if (chk2_en && (q_i != chk2_exp)) begin
        err_o <= 1'b1;
        if (err_cnt_o != 8'(ERR_MAX)) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Scoreboard bench: two drivers (fill modes 0 and 1), each with a behavioural jkff.
`timescale 1ns/1ps
module tb_jk_pattern_driver;

  localparam int W  = 8;
  localparam int HN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         stuck;
  logic [1:0]   ready_w, j_w, k_w, busy_w, done_w, err_w, q_ff_all, q_w;
  logic [7:0]   cnt_w [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    logic q_ff;
    jk_pattern_driver #(.WIDTH(W), .EXC_MODE(m)) dut (
      .clk         (clk),
      .rst         (rst),
      .tgt_valid_i (tgt_valid),
      .tgt_data_i  (tgt_data),
      .tgt_ready_o (ready_w[m]),
      .j_o         (j_w[m]),
      .k_o         (k_w[m]),
      .q_i         (q_w[m]),
      .busy_o      (busy_w[m]),
      .done_o      (done_w[m]),
      .err_o       (err_w[m]),
      .err_cnt_o   (cnt_w[m])
    );
    // Behavioural JK flip-flop with no reset.
    always @(posedge clk) begin
      case ({j_w[m], k_w[m]})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
    assign q_ff_all[m] = q_ff;
    assign q_w[m]      = stuck ? 1'b0 : q_ff;
  end

  typedef struct packed {
    logic [31:0]    acc;
    logic           init;
    logic           stuck;
    logic [W-1:0]   data;
    logic [2*W-1:0] jk0;
    logic [2*W-1:0] jk1;
    logic [31:0]    cnt;
  } exp_t;

  exp_t sbq[$];

  logic       m_synced, m_qexp;
  int         m_cnt;
  logic [1:0] h_jk0 [HN];
  logic [1:0] h_jk1 [HN];
  logic [1:0] h_q   [HN];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp_v);
    end
  endtask

  // Reference: the wanted flip-flop transition q->t, written as set/reset/toggle intent.
  function automatic void push_exp(input logic [W-1:0] d, input int acc);
    exp_t e;
    logic q, t;
    int   ones;
    e       = '0;
    e.acc   = acc;
    e.init  = !m_synced;
    e.stuck = stuck;
    e.data  = d;
    q       = e.init ? 1'b0 : m_qexp;
    ones    = 0;
    for (int i = 0; i < W; i++) begin
      t = d[i];
      e.jk0[2*i +: 2] = {(!q && t), (q && !t)};
      e.jk1[2*i +: 2] = {q != t, q != t};
      q = t;
      if (t) ones++;
    end
    m_qexp   = q;
    m_synced = 1'b1;
    if (stuck) m_cnt = (m_cnt + ones > 255) ? 255 : m_cnt + ones;
    e.cnt = m_cnt;
    sbq.push_back(e);
  endfunction

  // Monitor: record history each cycle, score a word on every done pulse.
  exp_t me;
  int   mb;
  always @(negedge clk) begin
    h_jk0[cyc % HN] = {j_w[0], k_w[0]};
    h_jk1[cyc % HN] = {j_w[1], k_w[1]};
    h_q[cyc % HN]   = q_ff_all;
    if (done_w != 2'b00) begin
      chk("done_both", int'(done_w), 3);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d actual=1 expected=0", cyc);
      end else begin
        me = sbq.pop_front();
        mb = int'(me.acc) + 1 + int'(me.init);
        chk("done_time", cyc, int'(me.acc) + W + 2 + int'(me.init));
        if (me.init) begin
          chk("init_jk0", int'(h_jk0[(mb - 1) % HN]), 1);
          chk("init_jk1", int'(h_jk1[(mb - 1) % HN]), 1);
        end
        for (int i = 0; i < W; i++) begin
          chk("bit_jk0", int'(h_jk0[(mb + i) % HN]), int'(me.jk0[2*i +: 2]));
          chk("bit_jk1", int'(h_jk1[(mb + i) % HN]), int'(me.jk1[2*i +: 2]));
          if (!me.stuck)
            chk("q_pattern", int'(h_q[(mb + 1 + i) % HN]), me.data[i] ? 3 : 0);
        end
        chk("err_cnt0", int'(cnt_w[0]), int'(me.cnt));
        chk("err_cnt1", int'(cnt_w[1]), int'(me.cnt));
        chk("err_flag", int'(err_w), (me.cnt != 0) ? 3 : 0);
        chk("ready_at_done", int'(ready_w), 3);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit keep);
    bit ok;
    ok        = 1'b0;
    tgt_valid = 1'b1;
    tgt_data  = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (ready_w[0]) begin
        push_exp(d, cyc);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout data=%0h actual=0 expected=1", d);
    end
    if (!keep) tgt_valid = 1'b0;
  endtask

  task automatic drain();
    tgt_valid = 1'b0;
    for (int t = 0; t < 400 && sbq.size() != 0; t++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    chk("idle_busy", int'(busy_w), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_jk"}, int'({j_w, k_w}), 0);
    chk({tag, "_ready"}, int'(ready_w), 3);
    chk({tag, "_busy"}, int'(busy_w), 0);
    chk({tag, "_done"}, int'(done_w), 0);
    chk({tag, "_err"}, int'(err_w), 0);
    chk({tag, "_cnt0"}, int'(cnt_w[0]), 0);
    chk({tag, "_cnt1"}, int'(cnt_w[1]), 0);
  endtask

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    stuck     = 1'b0;
    m_synced  = 1'b0;
    m_qexp    = 1'b0;
    m_cnt     = 0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);

    send(8'hA5, 1'b0);
    drain();
    send(8'hFF, 1'b1);
    send(8'h00, 1'b0);
    drain();
    send(8'h55, 1'b0);
    drain();

    stuck = 1'b1;
    send(8'hF0, 1'b0);
    drain();
    for (int n = 0; n < 300; n++) send(8'hFF, 1'b1);
    drain();
    stuck = 1'b0;

    for (int n = 0; n < 40; n++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      send(W'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Abort a word while its bit 3 is on j/k.
    send(8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    m_synced = 1'b0;
    m_cnt    = 0;
    @(negedge clk);
    chk_reset("mid");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send(8'h01, 1'b0);
    drain();

    for (int n = 0; n < 10; n++) send(W'($urandom), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
